controlador_execucao: RTL and testbench
=======================================

// Module: controlador_execucao
// PURPOSE
//  Upstream run controller for processador_multiciclo on the FPGA board; drives its Run input and consumes its Done.
//  Turns a raw pushbutton into clean start events. Two modes: single-step (one instruction per press) or continuous.
//  Stops continuous execution on a pause request or on an instruction-count limit.
//  A watchdog flags a hung instruction (Done never returns).
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable cycles needed to accept a new button level (bench overrides to 4)
//  TIMEOUT_CYCLES   16      max cycles in EXECUTA without Done before entering ERRO
//  CNT_W            16      width of instruction counter and Limite
// PORTS
//  Clock           in   1      system clock, rising edge
//  Resetn          in   1      asynchronous active-low reset
//  Botao           in   1      raw pushbutton, 1 = pressed, asynchronous to Clock
//  Modo            in   1      0 = single-step, 1 = continuous; sampled only on an accepted press
//  Pausa           in   1      level; in continuous mode, stop at the next Done
//  Limpa           in   1      synchronous clear: count, error, limit flag; forces OCIOSO
//  Limite          in   CNT_W  instruction limit; 0 = unlimited
//  Done            in   1      end-of-instruction pulse from processor
//  Run             out  1      run enable to processor (registered)
//  Ocupado         out  1      1 while in EXECUTA
//  Erro            out  1      1 while in ERRO (watchdog expired)
//  LimiteAtingido  out  1      (Limite != 0) && (ContaInstr >= Limite), combinational from registers
//  ContaInstr      out  CNT_W  Done pulses counted since reset/Limpa
// BEHAVIOUR
//  Reset (async, Resetn=0): state=OCIOSO, Run=0, Ocupado=0, Erro=0, ContaInstr=0, continuo=0, stop_req=0,
//   watchdog=0, debounced level=0, sync FFs=0.
//  Button path:
//   - 2-FF synchroniser.
//   - Debounced level updates only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles;
//     any bounce restarts the count.
//   - Press event = 1-cycle rising edge of the debounced level.
//   - Raw press to Run=1 latency: 2 + DEBOUNCE_CYCLES + 1 cycles. Holding the button never repeats.
//  FSM states: OCIOSO, EXECUTA, ERRO. Limpa has top priority in every state: next=OCIOSO, Run=0, counters cleared.
//  OCIOSO:
//   - Press && !LimiteAtingido -> EXECUTA; Run=1 from the next edge; continuo<=Modo; stop_req<=0; watchdog<=0.
//   - Press while LimiteAtingido is ignored.
//  EXECUTA:
//   - Run=1. Pausa=1 sets stop_req (sticky). Further presses are ignored.
//   - Watchdog increments every cycle. On Done=1: ContaInstr++ (wraps 2^CNT_W-1 -> 0); watchdog<=0.
//   - If !continuo || stop_req || Pausa || (count+1 reaches Limite != 0): next=OCIOSO, Run=0 from the next edge.
//     Run is still 1 on the Done edge, so the processor step counter clears normally.
//   - Otherwise stay in EXECUTA.
//   - Watchdog reaching TIMEOUT_CYCLES with Done=0 -> ERRO. Done in that same cycle wins (counted, no error).
//  ERRO:
//   - Run=0, Erro=1. Only Limpa or Resetn exits; presses are ignored.
//  Mid-instruction stop (Limpa): Run falls and the processor freezes in its current Tstep.
//   The processor is not reset; that is the operator's concern.
//  Limite changed while running takes effect at the next Done comparison.
//  Done while in OCIOSO/ERRO is ignored (not counted).
// STRUCTURE
//  Shared package/header defs_controlador.vh: state encodings (OCIOSO=2'd0, EXECUTA=2'd1, ERRO=2'd2),
//   default CNT_W and TIMEOUT_CYCLES.
//  One sub-module, debounce_botao (sync + debounce + rising-edge pulse; params DEBOUNCE_CYCLES).
//  The FSM, counters and watchdog live in this top module.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16, Done model fires 3 cycles after Run rises, every 3 cycles)
//  1. Reset then idle: all outputs 0. Botao glitch 1 for 2 cycles -> no Run.
//     Clean press of 10 cycles -> Run=1 exactly 7 cycles after Botao rises.
//  2. Single-step, Modo=0: one press -> exactly one Done seen with Run=1, Run=0 next cycle, ContaInstr=1.
//     Button held 100 cycles -> still 1.
//  3. Continuous, Modo=1, Limite=5: press -> Run stays 1 across Dones; stops after 5th Done;
//     ContaInstr=5, LimiteAtingido=1. New press ignored; Limpa -> count 0, flag 0.
//  4. Continuous, Limite=0: assert Pausa 1 cycle between Dones -> stops after the next Done, Run=0, Ocupado=0.
//  5. Done model disabled: press -> after 16 cycles Erro=1, Run=0. Presses ignored; Limpa -> Erro=0, OCIOSO.
//     Done and timeout in the same cycle -> counted, Erro stays 0.
//  6. Preload ContaInstr=16'hFFFF via 65535 steps (or force) -> next Done wraps to 0.
//     Resetn pulse mid-EXECUTA -> Run=0 immediately (async), all outputs reset.

Source files
------------

// File: rtl/controlador_execucao_pkg.sv
// Shared definitions for the run controller: FSM state encoding and default widths/limits.
package controlador_execucao_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    ERRO    = 2'd2
  } estado_t;

  localparam int CNT_W_PADRAO   = 16;
  localparam int TIMEOUT_PADRAO = 16;

endpackage

// File: rtl/controlador_execucao_debounce_botao.sv
// Pushbutton cleaner: 2-FF synchroniser, stability debounce, 1-cycle pulse on the accepted rising level.
// Raw edge to pulse is 2 + DEBOUNCE_CYCLES cycles; a held button produces a single pulse.
module debounce_botao #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic botao,
  output logic pulso
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sinc1;
  logic          sinc2;
  logic          nivel;
  logic          nivel_ant;
  logic [CW-1:0] conta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc1     <= 1'b0;
      sinc2     <= 1'b0;
      nivel     <= 1'b0;
      nivel_ant <= 1'b0;
      conta     <= '0;
    end else begin
      sinc1     <= botao;
      sinc2     <= sinc1;
      nivel_ant <= nivel;
      // Any sample that agrees with the current level restarts the stability count.
      if (sinc2 == nivel) begin
        conta <= '0;
      end else if (conta == CW'(DEBOUNCE_CYCLES - 1)) begin
        nivel <= sinc2;
        conta <= '0;
      end else begin
        conta <= conta + 1'b1;
      end
    end
  end

  assign pulso = nivel & ~nivel_ant;

endmodule

// File: rtl/controlador_execucao.sv
// Run controller for the multicycle processor: single-step/continuous execution, pause, instruction limit, watchdog.
// Run is registered: a press reaches Run one cycle after the debounced pulse; Run drops on the edge that samples the final Done.
module controlador_execucao
  import controlador_execucao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_PADRAO,
  parameter int CNT_W           = CNT_W_PADRAO
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Botao,
  input  logic             Modo,
  input  logic             Pausa,
  input  logic             Limpa,
  input  logic [CNT_W-1:0] Limite,
  input  logic             Done,
  output logic             Run,
  output logic             Ocupado,
  output logic             Erro,
  output logic             LimiteAtingido,
  output logic [CNT_W-1:0] ContaInstr
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  estado_t          estado;
  estado_t          estado_nxt;
  logic [CNT_W-1:0] conta_nxt;
  logic [CNT_W-1:0] conta_inc;
  logic [WD_W-1:0]  wd;
  logic [WD_W-1:0]  wd_nxt;
  logic [WD_W-1:0]  wd_inc;
  logic             continuo;
  logic             continuo_nxt;
  logic             stop_req;
  logic             stop_nxt;
  logic             pressao;
  logic             limite_prox;

  debounce_botao #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (Clock),
    .rst_n(Resetn),
    .botao(Botao),
    .pulso(pressao)
  );

  assign conta_inc      = ContaInstr + 1'b1;
  assign wd_inc         = wd + 1'b1;
  // Limite is compared live, so a change while running applies at the next Done.
  assign limite_prox    = (Limite != '0) && (conta_inc >= Limite);
  assign LimiteAtingido = (Limite != '0) && (ContaInstr >= Limite);
  assign Ocupado        = (estado == EXECUTA);
  assign Erro           = (estado == ERRO);

  always_comb begin
    estado_nxt   = estado;
    conta_nxt    = ContaInstr;
    wd_nxt       = wd;
    continuo_nxt = continuo;
    stop_nxt     = stop_req;

    if (Limpa) begin
      estado_nxt = OCIOSO;
      conta_nxt  = '0;
      wd_nxt     = '0;
      stop_nxt   = 1'b0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (pressao && !LimiteAtingido) begin
            estado_nxt   = EXECUTA;
            continuo_nxt = Modo;
            stop_nxt     = 1'b0;
            wd_nxt       = '0;
          end
        end
        EXECUTA: begin
          if (Pausa) begin
            stop_nxt = 1'b1;
          end
          // Done takes precedence over a watchdog expiring in the same cycle.
          if (Done) begin
            conta_nxt = conta_inc;
            wd_nxt    = '0;
            if (!continuo || stop_req || Pausa || limite_prox) begin
              estado_nxt = OCIOSO;
            end
          end else if (wd_inc == WD_W'(TIMEOUT_CYCLES)) begin
            estado_nxt = ERRO;
          end else begin
            wd_nxt = wd_inc;
          end
        end
        ERRO: begin
          estado_nxt = ERRO;
        end
        default: begin
          estado_nxt = OCIOSO;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      estado     <= OCIOSO;
      Run        <= 1'b0;
      ContaInstr <= '0;
      wd         <= '0;
      continuo   <= 1'b0;
      stop_req   <= 1'b0;
    end else begin
      estado     <= estado_nxt;
      Run        <= (estado_nxt == EXECUTA);
      ContaInstr <= conta_nxt;
      wd         <= wd_nxt;
      continuo   <= continuo_nxt;
      stop_req   <= stop_nxt;
    end
  end

endmodule

// File: tb/tb_controlador_execucao.sv
// Bench for controlador_execucao: event-level reference model compared every cycle, directed scenarios, then random traffic.
module tb_controlador_execucao;

  localparam int D  = 4;
  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        Botao;
  logic        Modo;
  logic        Pausa;
  logic        Limpa;
  logic [15:0] Limite;
  logic        Done;
  logic        Run;
  logic        Ocupado;
  logic        Erro;
  logic        LimiteAtingido;
  logic [15:0] ContaInstr;

  int nerr;
  int nchk;
  int done_seen;
  int done_period;
  bit done_noise;
  int ph;

  controlador_execucao #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (16)
  ) dut (
    .Clock         (clk),
    .Resetn        (rst_n),
    .Botao         (Botao),
    .Modo          (Modo),
    .Pausa         (Pausa),
    .Limpa         (Limpa),
    .Limite        (Limite),
    .Done          (Done),
    .Run           (Run),
    .Ocupado       (Ocupado),
    .Erro          (Erro),
    .LimiteAtingido(LimiteAtingido),
    .ContaInstr    (ContaInstr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Processor stand-in: Done every done_period cycles of Run, plus optional random noise.
  initial begin
    Done = 1'b0;
    ph   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (Run) ph++;
      else ph = 0;
      Done = (done_period > 0 && Run && (ph % done_period) == 0) ||
             (done_noise && $urandom_range(0, 7) == 0);
    end
  end

  // Reference model: button as a sample history, controller as run/error flags plus counters.
  bit          m_s1, m_s2, m_smp, m_deb, m_press, m_all;
  bit          m_hist[$];
  bit          m_run, m_err, m_cont, m_stop, m_fin;
  int          m_age;
  logic [15:0] m_cnt;

  initial begin
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0;
    m_run = 0; m_err = 0; m_cont = 0; m_stop = 0; m_age = 0; m_cnt = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0; m_hist.delete();
        m_run = 0; m_err = 0; m_cont = 0; m_stop = 0; m_age = 0; m_cnt = '0;
      end else begin
        if (Limpa) begin
          m_run = 0; m_err = 0; m_cnt = '0; m_stop = 0; m_age = 0;
        end else if (m_err) begin
          m_err = 1;
        end else if (m_run) begin
          m_fin = !m_cont || m_stop || Pausa;
          if (Pausa) m_stop = 1;
          m_age++;
          if (Done) begin
            m_cnt = m_cnt + 16'd1;
            m_age = 0;
            if (m_fin || (Limite != 0 && m_cnt >= Limite)) m_run = 0;
          end else if (m_age >= TO) begin
            m_run = 0;
            m_err = 1;
          end
        end else if (m_press && !(Limite != 0 && m_cnt >= Limite)) begin
          m_run = 1; m_cont = Modo; m_stop = 0; m_age = 0;
        end
        m_smp = m_s2; m_s2 = m_s1; m_s1 = Botao;
        m_hist.push_back(m_smp);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        m_press = 0;
        if (m_hist.size() == D) begin
          m_all = 1;
          for (int i = 0; i < D; i++) if (m_hist[i] == m_deb) m_all = 0;
          if (m_all) begin
            m_deb = !m_deb;
            m_hist.delete();
            m_press = m_deb;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare everything against the model mid-cycle, then return just after the next edge.
  task automatic cyc();
    @(negedge clk);
    chk("run", 32'(Run), 32'(m_run));
    chk("ocupado", 32'(Ocupado), 32'(m_run));
    chk("erro", 32'(Erro), 32'(m_err));
    chk("limite_atingido", 32'(LimiteAtingido), 32'(Limite != 0 && m_cnt >= Limite));
    chk("conta", 32'(ContaInstr), 32'(m_cnt));
    if (Done && Run) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic limpa();
    Limpa = 1'b1;
    cyc();
    Limpa = 1'b0;
    cyc();
  endtask

  task automatic press_watch(input int hold, input int maxc,
                             output int t_run, output int t_err, output int run_cyc);
    t_run = -1; t_err = -1; run_cyc = 0;
    Botao = 1'b1;
    for (int k = 1; k <= maxc; k++) begin
      cyc();
      if (k == hold) Botao = 1'b0;
      if (Run) run_cyc++;
      if (Run && t_run < 0) t_run = k;
      if (Erro && t_err < 0) t_err = k;
    end
    Botao = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    while (Ocupado && k < maxc) begin
      cyc();
      k++;
    end
    chk(nm, 32'(Ocupado), 32'd0);
  endtask

  initial begin
    int t_run, t_err, run_cyc, k;
    bit seen;
    nerr = 0; nchk = 0; done_seen = 0;
    Botao = 0; Modo = 0; Pausa = 0; Limpa = 0; Limite = '0;
    done_period = 3; done_noise = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    chk("rst_run", 32'(Run), 32'd0);
    chk("rst_erro", 32'(Erro), 32'd0);
    chk("rst_conta", 32'(ContaInstr), 32'd0);

    // Glitch then clean press
    seen = 0;
    Botao = 1'b1; cyc(); cyc(); Botao = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (Run) seen = 1;
    end
    chk("glitch_no_run", 32'(seen), 32'd0);
    press_watch(10, 25, t_run, t_err, run_cyc);
    chk("press_latency", 32'(t_run), 32'd7);
    chk("step_run_len", 32'(run_cyc), 32'd3);

    // Single step, then long hold
    limpa();
    done_seen = 0;
    press_watch(10, 25, t_run, t_err, run_cyc);
    wait_idle(50, "t2_idle");
    chk("t2_dones", 32'(done_seen), 32'd1);
    chk("t2_conta", 32'(ContaInstr), 32'd1);
    limpa();
    done_seen = 0;
    press_watch(100, 110, t_run, t_err, run_cyc);
    chk("t2_hold_conta", 32'(ContaInstr), 32'd1);
    chk("t2_hold_dones", 32'(done_seen), 32'd1);

    // Continuous with limit 5
    limpa();
    Modo = 1'b1; Limite = 16'd5;
    press_watch(10, 25, t_run, t_err, run_cyc);
    wait_idle(200, "t3_idle");
    chk("t3_conta", 32'(ContaInstr), 32'd5);
    chk("t3_flag", 32'(LimiteAtingido), 32'd1);
    press_watch(10, 25, t_run, t_err, run_cyc);
    chk("t3_press_ignored", 32'(t_run), 32'hFFFF_FFFF);
    limpa();
    chk("t3_limpa_conta", 32'(ContaInstr), 32'd0);
    chk("t3_limpa_flag", 32'(LimiteAtingido), 32'd0);

    // Continuous, unlimited, pause between Dones
    Limite = '0;
    press_watch(10, 12, t_run, t_err, run_cyc);
    k = 0;
    while (ContaInstr != 16'd2 && k < 100) begin cyc(); k++; end
    chk("t4_reach2", 32'(ContaInstr), 32'd2);
    Pausa = 1'b1; cyc(); Pausa = 1'b0;
    wait_idle(100, "t4_idle");
    chk("t4_conta", 32'(ContaInstr), 32'd3);
    chk("t4_run", 32'(Run), 32'd0);

    // Watchdog
    limpa();
    done_period = 0; Modo = 1'b0;
    press_watch(10, 40, t_run, t_err, run_cyc);
    chk("t5_timeout", 32'(t_err - t_run), 32'd16);
    chk("t5_run", 32'(Run), 32'd0);
    chk("t5_erro", 32'(Erro), 32'd1);
    press_watch(10, 25, t_run, t_err, run_cyc);
    chk("t5_press_ignored", 32'(t_run), 32'hFFFF_FFFF);
    limpa();
    chk("t5_limpa_erro", 32'(Erro), 32'd0);
    done_period = 16;
    press_watch(10, 40, t_run, t_err, run_cyc);
    wait_idle(40, "t5_coinc_idle");
    chk("t5_coinc_erro", 32'(Erro), 32'd0);
    chk("t5_coinc_conta", 32'(ContaInstr), 32'd1);

    // Counter wrap
    limpa();
    done_period = 1; Modo = 1'b1; Limite = 16'hFFFF;
    press_watch(10, 20, t_run, t_err, run_cyc);
    wait_idle(70000, "t6_fill_idle");
    chk("t6_full", 32'(ContaInstr), 32'h0000_FFFF);
    Limite = '0; Modo = 1'b0; done_period = 3;
    press_watch(10, 25, t_run, t_err, run_cyc);
    wait_idle(50, "t6_wrap_idle");
    chk("t6_wrap", 32'(ContaInstr), 32'd0);

    // Asynchronous reset mid-run
    Modo = 1'b1;
    press_watch(10, 12, t_run, t_err, run_cyc);
    chk("t6_running", 32'(Run), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_run", 32'(Run), 32'd0);
    chk("t6_rst_ocupado", 32'(Ocupado), 32'd0);
    chk("t6_rst_conta", 32'(ContaInstr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      Modo = 1'($urandom_range(0, 1));
      Limite = 16'($urandom_range(0, 6));
      case ($urandom_range(0, 6))
        0: done_period = 1;
        1: done_period = 2;
        2: done_period = 3;
        3: done_period = 5;
        4: done_period = 16;
        5: done_period = 17;
        default: done_period = 0;
      endcase
      done_noise = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < 120; c++) begin
        if ($urandom_range(0, 9) == 0) Botao = ~Botao;
        if ($urandom_range(0, 59) == 0) Limite = 16'($urandom_range(0, 6));
        Pausa = ($urandom_range(0, 29) == 0);
        Limpa = ($urandom_range(0, 79) == 0);
        cyc();
      end
    end
    Pausa = 0; Limpa = 0; Botao = 0; done_noise = 0;
    repeat (4) cyc();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
